// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - round-robin sequencer sharing one data-memory port among NUM_REQ requesters
// Optional ack watchdog enabled by defining DMEM_ARB_TIMEOUT_EN.
module dmem_port_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int OP_W           = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*OP_W-1:0]   req_op_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic [NUM_REQ-1:0]        req_done_o,
  output logic [DATA_W-1:0]         req_rdata_o,
  output logic                      req_err_o,
  input  logic                      memory_ready_i,
  input  logic                      memory_ack_i,
  input  logic [DATA_W-1:0]         memory_data_return_i,
  output logic                      memory_req_valid_o,
  output logic [OP_W-1:0]           memory_req_op_o,
  output logic [ADDR_W-1:0]         memory_req_address_o,
  output logic [DATA_W-1:0]         memory_req_data_o
);

  localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("dmem_port_arbiter: NUM_REQ must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_ACK, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [RW-1:0]       rr_ptr_q, rr_ptr_d, owner_q, winner;
  logic [RW:0]         cand;
  logic                found, grant, busy, timeout;
  logic [OP_W-1:0]     op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    winner = rr_ptr_q;
    found  = 1'b0;
    cand   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + (RW+1)'(i);
      if (cand >= (RW+1)'(NUM_REQ)) cand = cand - (RW+1)'(NUM_REQ);
      if (!found && req_valid_i[cand[RW-1:0]]) begin
        found  = 1'b1;
        winner = cand[RW-1:0];
      end
    end
  end

  assign grant    = (state_q == S_IDLE) && memory_ready_i && found;
  assign busy     = (state_q == S_ISSUE) || (state_q == S_WAIT_ACK);
  assign rr_ptr_d = (winner == RW'(NUM_REQ - 1)) ? '0 : winner + RW'(1);

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (grant) state_d = S_ISSUE;
      S_ISSUE,
      S_WAIT_ACK: if (memory_ack_i || timeout) state_d = S_RESP;
                  else                         state_d = S_WAIT_ACK;
      S_RESP:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = '0;
    req_done_o  = '0;
    if (grant)              req_ready_o[winner]  = 1'b1;
    if (state_q == S_RESP)  req_done_o[owner_q]  = 1'b1;
    memory_req_valid_o = (state_q == S_ISSUE);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_ptr_q <= '0;
      owner_q  <= '0;
      op_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      if (grant) begin
        rr_ptr_q <= rr_ptr_d;
        owner_q  <= winner;
        op_q     <= req_op_i[int'(winner)*OP_W +: OP_W];
        addr_q   <= req_addr_i[int'(winner)*ADDR_W +: ADDR_W];
        wdata_q  <= req_wdata_i[int'(winner)*DATA_W +: DATA_W];
      end
      if (busy && memory_ack_i) rdata_q <= memory_data_return_i;
      else if (busy && timeout) rdata_q <= '0;
    end
  end

  assign memory_req_op_o      = op_q;
  assign memory_req_address_o = addr_q;
  assign memory_req_data_o    = wdata_q;
  assign req_rdata_o          = rdata_q;

`ifdef DMEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic          err_q;

  // The count covers ISSUE and WAIT_ACK cycles; the last allowed cycle forces RESP.
  assign timeout = busy && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (grant)     cnt_q <= '0;
      else if (busy) cnt_q <= cnt_q + CW'(1);
      if (busy && memory_ack_i) err_q <= 1'b0;
      else if (busy && timeout) err_q <= 1'b1;
    end
  end

  assign req_err_o = err_q;
`else
  assign timeout   = 1'b0;
  assign req_err_o = 1'b0;
`endif

endmodule
